// File: rtl/scan_pat_pkg.sv
// scan_pat_pkg: shared types and helpers for the scan pattern engine.
//   st_e     - engine FSM state encoding
//   vec_w()  - width of the vector (shift position) counter for a chain length
//   ch_w()   - width of a chain index for a chain count
//   cnt_w()  - width of a popcount over NCHAIN bits
//   sat_add()- unsigned add clamped at 2^w-1
package scan_pat_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        SE_FALL = 3'd2,
        CAPTURE = 3'd3,
        SE_RISE = 3'd4,
        DONE    = 3'd5
    } st_e;

    function automatic int vec_w(input int chain_len);
        return (chain_len > 2) ? $clog2(chain_len) : 1;
    endfunction

    // A single chain still needs a 1-bit index field.
    function automatic int ch_w(input int nchain);
        return (nchain > 1) ? $clog2(nchain) : 1;
    endfunction

    function automatic int cnt_w(input int nchain);
        return $clog2(nchain + 1);
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int          w);
        logic [64:0] sum;
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sum   = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[63:0];
    endfunction

endpackage

// File: rtl/scan_cmp.sv
// scan_cmp: purely combinational unload comparator.
//   so_i   - chain outputs, exp_i - expected bits, msk_i - 1 = compare
//   diff_o - masked miscompare vector
//   pop_o  - number of miscomparing chains
//   low_o  - lowest miscomparing chain index (0 when none)
//   any_o  - at least one miscompare
module scan_cmp
    import scan_pat_pkg::*;
#(
    parameter int NCHAIN = 8
) (
    input  logic [NCHAIN-1:0]          so_i,
    input  logic [NCHAIN-1:0]          exp_i,
    input  logic [NCHAIN-1:0]          msk_i,
    output logic [NCHAIN-1:0]          diff_o,
    output logic [cnt_w(NCHAIN)-1:0]   pop_o,
    output logic [ch_w(NCHAIN)-1:0]    low_o,
    output logic                       any_o
);

    localparam int CW  = cnt_w(NCHAIN);
    localparam int CHW = ch_w(NCHAIN);

    always_comb begin
        diff_o = (so_i ^ exp_i) & msk_i;
        pop_o  = '0;
        low_o  = '0;
        // Walk from the top so the lowest set bit is the last one written.
        for (int i = NCHAIN - 1; i >= 0; i--) begin
            pop_o = pop_o + CW'(diff_o[i]);
            if (diff_o[i]) begin
                low_o = CHW'(i);
            end
        end
        any_o = |diff_o;
    end

endmodule

// File: rtl/scan_pat_engine.sv
// scan_pat_engine: replays ATPG load/unload/capture sequences over NCHAIN
// parallel scan chains and compares unloaded data against masked expects.
//   clk, rst (sync, active high), start, abort, num_pat
//   beat_valid/beat_ready + beat_si/beat_exp/beat_msk : pattern beat stream
//   scan_so in, scan_si/scan_en/shift_clk_en/cap_clk_en out : chain side
//   busy, done, pattern_number, vector_number, mis_cnt : progress/status
//   fail_vld, fail_pat, fail_vec, fail_chain : first failure record
//   dbg_state : current FSM state
//
// Handshake: a beat transfers on a rising clk edge where beat_valid and
// beat_ready are both high; beat_ready is high only in SHIFT and is pulled
// low by abort/rst so no beat is consumed on a cancelling edge.
//
// Chain-side outputs are registered, so every one of them reflects the
// previous cycle's decision. The shift edge for an accepted beat is the edge
// that ends the cycle in which shift_clk_en is high; scan_so is compared in
// that same cycle (before the shift), which is why the compare runs one
// cycle behind acceptance on latched expect/mask data.
module scan_pat_engine
    import scan_pat_pkg::*;
#(
    parameter int NCHAIN    = 8,
    parameter int CHAIN_LEN = 256,
    parameter int PAT_W     = 16,
    parameter int MIS_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [PAT_W-1:0]              num_pat,
    input  logic                          beat_valid,
    output logic                          beat_ready,
    input  logic [NCHAIN-1:0]             beat_si,
    input  logic [NCHAIN-1:0]             beat_exp,
    input  logic [NCHAIN-1:0]             beat_msk,
    input  logic [NCHAIN-1:0]             scan_so,
    output logic [NCHAIN-1:0]             scan_si,
    output logic                          scan_en,
    output logic                          shift_clk_en,
    output logic                          cap_clk_en,
    output logic                          busy,
    output logic                          done,
    output logic [PAT_W-1:0]              pattern_number,
    output logic [vec_w(CHAIN_LEN)-1:0]   vector_number,
    output logic [MIS_W-1:0]              mis_cnt,
    output logic                          fail_vld,
    output logic [PAT_W-1:0]              fail_pat,
    output logic [vec_w(CHAIN_LEN)-1:0]   fail_vec,
    output logic [ch_w(NCHAIN)-1:0]       fail_chain,
    output logic [2:0]                    dbg_state
);

    localparam int VEC_W = vec_w(CHAIN_LEN);
    localparam int CH_W  = ch_w(NCHAIN);
    localparam int CW    = cnt_w(NCHAIN);

    st_e              state_q;
    logic [PAT_W-1:0] num_pat_q;
    logic [NCHAIN-1:0] exp_q;
    logic [NCHAIN-1:0] msk_q;
    logic [PAT_W-1:0] tag_pat_q;
    logic [VEC_W-1:0] tag_vec_q;
    logic             accept;

    logic [NCHAIN-1:0] cmp_diff;
    logic [CW-1:0]     cmp_pop;
    logic [CH_W-1:0]   cmp_low;
    logic              cmp_any;

    assign beat_ready = (state_q == SHIFT) && !abort && !rst;
    assign accept     = beat_valid && beat_ready;
    assign busy       = (state_q == SHIFT) || (state_q == SE_FALL) ||
                        (state_q == CAPTURE) || (state_q == SE_RISE);
    assign dbg_state  = state_q;

    scan_cmp #(.NCHAIN(NCHAIN)) u_cmp (
        .so_i   (scan_so),
        .exp_i  (exp_q),
        .msk_i  (msk_q),
        .diff_o (cmp_diff),
        .pop_o  (cmp_pop),
        .low_o  (cmp_low),
        .any_o  (cmp_any)
    );

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_q        <= IDLE;
            num_pat_q      <= '0;
            pattern_number <= '0;
            vector_number  <= '0;
            mis_cnt        <= '0;
            fail_vld       <= 1'b0;
            fail_pat       <= '0;
            fail_vec       <= '0;
            fail_chain     <= '0;
            scan_si        <= '0;
            scan_en        <= 1'b0;
            shift_clk_en   <= 1'b0;
            cap_clk_en     <= 1'b0;
            done           <= 1'b0;
            exp_q          <= '0;
            msk_q          <= '0;
            tag_pat_q      <= '0;
            tag_vec_q      <= '0;
        end else begin
            scan_en      <= (state_q == SHIFT) || (state_q == SE_RISE);
            shift_clk_en <= accept;
            cap_clk_en   <= (state_q == CAPTURE);

            if (accept) begin
                scan_si   <= beat_si;
                exp_q     <= beat_exp;
                msk_q     <= beat_msk;
                tag_pat_q <= pattern_number;
                tag_vec_q <= vector_number;
            end

            // Compare stage: shift_clk_en high marks a beat awaiting compare.
            if (shift_clk_en && cmp_any) begin
                mis_cnt <= MIS_W'(sat_add(64'(mis_cnt), 64'(cmp_pop), MIS_W));
                if (!fail_vld) begin
                    fail_vld   <= 1'b1;
                    fail_pat   <= tag_pat_q;
                    fail_vec   <= tag_vec_q;
                    fail_chain <= cmp_low;
                end
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        num_pat_q      <= num_pat;
                        pattern_number <= '0;
                        vector_number  <= '0;
                        mis_cnt        <= '0;
                        fail_vld       <= 1'b0;
                        fail_pat       <= '0;
                        fail_vec       <= '0;
                        fail_chain     <= '0;
                        done           <= 1'b0;
                        state_q        <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        if (vector_number == VEC_W'(CHAIN_LEN - 1)) begin
                            vector_number <= '0;
                            if (pattern_number < num_pat_q) begin
                                state_q <= SE_FALL;
                            end else begin
                                state_q <= DONE;
                                done    <= 1'b1;
                            end
                        end else begin
                            vector_number <= vector_number + VEC_W'(1);
                        end
                    end
                end
                SE_FALL: state_q <= CAPTURE;
                CAPTURE: state_q <= SE_RISE;
                SE_RISE: begin
                    pattern_number <= pattern_number + PAT_W'(1);
                    state_q        <= SHIFT;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_pat_engine.sv
// Bench for scan_pat_engine: a behavioural core model (chains shift on
// shift_clk_en, invert their contents on cap_clk_en) drives scan_so. Expected
// unload of group g beat k is the inverse of the stimulus loaded at group g-1
// beat k; group 0 is masked. Flips injected into the expect stream are the
// only miscompares, and a reference model derives counts/first-failure.
module tb_scan_pat_engine;
  localparam int NC = 4;
  localparam int L  = 8;
  localparam int PW = 16;
  localparam int MW = 16;

  logic clk = 1'b0;
  logic rst, start, abort, beat_valid;
  logic [PW-1:0] num_pat;
  logic [NC-1:0] beat_si, beat_exp, beat_msk, scan_so;

  logic beat_ready, scan_en, shift_clk_en, cap_clk_en, busy, done, fail_vld;
  logic [NC-1:0] scan_si;
  logic [PW-1:0] pattern_number, fail_pat;
  logic [2:0] vector_number, fail_vec, dbg_state;
  logic [MW-1:0] mis_cnt;
  logic [1:0] fail_chain;

  logic beat_ready2, scan_en2, shift_clk_en2, cap_clk_en2, busy2, done2, fail_vld2;
  logic [NC-1:0] scan_si2;
  logic [PW-1:0] pattern_number2, fail_pat2;
  logic [2:0] vector_number2, fail_vec2, dbg_state2;
  logic [1:0] mis_cnt2;
  logic [1:0] fail_chain2;

  always #5 clk = ~clk;

  scan_pat_engine #(.NCHAIN(NC), .CHAIN_LEN(L), .PAT_W(PW), .MIS_W(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_pat(num_pat),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_si(beat_si),
    .beat_exp(beat_exp), .beat_msk(beat_msk), .scan_so(scan_so),
    .scan_si(scan_si), .scan_en(scan_en), .shift_clk_en(shift_clk_en),
    .cap_clk_en(cap_clk_en), .busy(busy), .done(done),
    .pattern_number(pattern_number), .vector_number(vector_number),
    .mis_cnt(mis_cnt), .fail_vld(fail_vld), .fail_pat(fail_pat),
    .fail_vec(fail_vec), .fail_chain(fail_chain), .dbg_state(dbg_state));

  scan_pat_engine #(.NCHAIN(NC), .CHAIN_LEN(L), .PAT_W(PW), .MIS_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_pat(num_pat),
    .beat_valid(beat_valid), .beat_ready(beat_ready2), .beat_si(beat_si),
    .beat_exp(beat_exp), .beat_msk(beat_msk), .scan_so(scan_so),
    .scan_si(scan_si2), .scan_en(scan_en2), .shift_clk_en(shift_clk_en2),
    .cap_clk_en(cap_clk_en2), .busy(busy2), .done(done2),
    .pattern_number(pattern_number2), .vector_number(vector_number2),
    .mis_cnt(mis_cnt2), .fail_vld(fail_vld2), .fail_pat(fail_pat2),
    .fail_vec(fail_vec2), .fail_chain(fail_chain2), .dbg_state(dbg_state2));

  // Core model: chains fed by scan_si, tails drive scan_so.
  logic [L-1:0] chain [NC];
  always @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (rst) chain[c] <= '0;
      else if (shift_clk_en) chain[c] <= {chain[c][L-2:0], scan_si[c]};
      else if (cap_clk_en) chain[c] <= ~chain[c];
    end
  end
  always_comb begin
    scan_so = '0;
    for (int c = 0; c < NC; c++) scan_so[c] = chain[c][L-1];
  end

  int sh_cnt = 0;
  int cap_cnt = 0;
  always @(posedge clk) begin
    if (shift_clk_en) sh_cnt <= sh_cnt + 1;
    if (cap_clk_en) cap_cnt <= cap_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [NC-1:0] si_a [64];
  logic [NC-1:0] exp_a [64];
  logic [NC-1:0] msk_a [64];
  logic [NC-1:0] flip_a [64];
  logic [NC-1:0] mo_a [64];

  task automatic prep();
    for (int i = 0; i < 64; i++) begin
      si_a[i] = NC'($urandom);
      flip_a[i] = '0;
      mo_a[i] = '0;
    end
  endtask

  task automatic finalize(input int n);
    for (int i = 0; i < (n + 1) * L; i++) begin
      if (i < L) begin
        exp_a[i] = NC'($urandom);
        msk_a[i] = '0;
      end else begin
        exp_a[i] = ~si_a[i - L] ^ flip_a[i];
        msk_a[i] = ~mo_a[i];
      end
    end
  endtask

  // Reference: miscompares are exactly the unmasked injected flips.
  task automatic model(input int n, input int maxv, output int mis, output bit fv,
                       output int fp, output int fvec, output int fch);
    logic [NC-1:0] d;
    mis = 0; fv = 0; fp = 0; fvec = 0; fch = 0;
    for (int i = 0; i < (n + 1) * L; i++) begin
      d = flip_a[i] & msk_a[i];
      mis = mis + $countones(d);
      if (mis > maxv) mis = maxv;
      if (d != 0 && !fv) begin
        fv = 1; fp = i / L; fvec = i % L;
        for (int c = NC - 1; c >= 0; c--) if (d[c]) fch = c;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_scan_si"}, scan_si, 0);
    chk({tag, "_scan_en"}, scan_en, 0);
    chk({tag, "_shift_en"}, shift_clk_en, 0);
    chk({tag, "_cap_en"}, cap_clk_en, 0);
    chk({tag, "_ready"}, beat_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pat"}, pattern_number, 0);
    chk({tag, "_vec"}, vector_number, 0);
    chk({tag, "_mis"}, mis_cnt, 0);
    chk({tag, "_mis2"}, mis_cnt2, 0);
    chk({tag, "_fvld"}, fail_vld, 0);
    chk({tag, "_fpat"}, fail_pat, 0);
    chk({tag, "_fvec"}, fail_vec, 0);
    chk({tag, "_fch"}, fail_chain, 0);
  endtask

  // kill_kind: 0 none, 1 abort, 2 rst (asserted when beat kill_at is offered)
  task automatic run(input int n, input int st_at, input int st_len, input int kill_at,
                     input int kill_kind, input bit poke, output int cyc);
    int idx, stc, total;
    bit acc, killed;
    idx = 0; stc = 0; cyc = 0; killed = 0; total = (n + 1) * L;
    @(negedge clk);
    start = 1'b1;
    num_pat = PW'(n);
    forever begin
      beat_valid = 1'b0;
      if (idx == st_at && stc < st_len) begin
        stc++;
        chk("stall_vec", vector_number, idx % L);
        if (stc >= 2) chk("stall_shift_en", shift_clk_en, 0);
      end else if (idx < total) begin
        beat_valid = 1'b1;
        beat_si = si_a[idx];
        beat_exp = exp_a[idx];
        beat_msk = msk_a[idx];
      end
      if (kill_kind != 0 && idx == kill_at && cyc > 0) begin
        chk("kill_pat", pattern_number, kill_at / L);
        chk("kill_vec", vector_number, kill_at % L);
        if (kill_kind == 1) abort = 1'b1; else rst = 1'b1;
        killed = 1;
      end
      #1;
      acc = beat_valid && beat_ready;
      if (killed) chk("kill_no_accept", acc, 0);
      @(posedge clk);
      cyc++;
      if (acc) idx++;
      #1;
      if (killed) begin
        check_reset_vals(kill_kind == 1 ? "abort" : "rst");
        break;
      end
      if (done) break;
      if (cyc > 2000) begin
        chk("run_timeout", cyc, -1);
        break;
      end
      @(negedge clk);
      start = 1'b0;
      if (poke && cyc == 5) begin
        start = 1'b1;
        num_pat = PW'(n + 1);
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; rst = 1'b0; beat_valid = 1'b0;
  endtask

  task automatic post_run(input string tag, input int n, input int cyc, input int e_cyc,
                          input int sh0, input int cap0, input int e_mis, input int e_mis2,
                          input bit fv, input int fp, input int fvec, input int fch);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_cycles"}, cyc, e_cyc);
    chk({tag, "_shifts"}, sh_cnt - sh0, (n + 1) * L);
    chk({tag, "_caps"}, cap_cnt - cap0, n);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pat"}, pattern_number, n);
    chk({tag, "_mis"}, mis_cnt, e_mis);
    chk({tag, "_mis2"}, mis_cnt2, e_mis2);
    chk({tag, "_fvld"}, fail_vld, fv);
    chk({tag, "_fpat"}, fail_pat, fp);
    chk({tag, "_fvec"}, fail_vec, fvec);
    chk({tag, "_fch"}, fail_chain, fch);
    chk({tag, "_fch2"}, fail_chain2, fch);
  endtask

  typedef struct {
    int n; int fl_i; logic [NC-1:0] fl; logic [NC-1:0] mo;
    int st_at; int st_len; bit poke;
    int e_mis; int e_mis2; bit e_fv; int e_fp; int e_fvec; int e_fch; int e_cyc;
  } row_t;
  row_t tbl [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, sh0, cap0, mis, mis2, fp, fvec, fch, n, st_at, st_len;
    bit fv;
    rst = 1'b1; start = 1'b0; abort = 1'b0; beat_valid = 1'b0;
    num_pat = '0; beat_si = '0; beat_exp = '0; beat_msk = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    //         n fl_i  fl     mo   st_at len poke mis m2 fv fp fvec fch cyc
    tbl[0] = '{2, -1, 4'h0, 4'h0, -1, 0, 1'b1, 0, 0, 1'b0, 0, 0, 0, 31};
    tbl[1] = '{2, 13, 4'h6, 4'h0, -1, 0, 1'b0, 2, 2, 1'b1, 1, 5, 1, 31};
    tbl[2] = '{2, 13, 4'h6, 4'h6, -1, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 31};
    tbl[3] = '{2, -1, 4'h0, 4'h0, 12, 3, 1'b0, 0, 0, 1'b0, 0, 0, 0, 34};
    tbl[4] = '{0, -1, 4'h0, 4'h0, -1, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 9};
    tbl[5] = '{1, 15, 4'h8, 4'h0, -1, 0, 1'b0, 1, 1, 1'b1, 1, 7, 3, 20};

    for (int r = 0; r < 6; r++) begin
      prep();
      if (tbl[r].fl_i >= 0) begin
        flip_a[tbl[r].fl_i] = tbl[r].fl;
        mo_a[tbl[r].fl_i] = tbl[r].mo;
      end
      finalize(tbl[r].n);
      sh0 = sh_cnt; cap0 = cap_cnt;
      run(tbl[r].n, tbl[r].st_at, tbl[r].st_len, -1, 0, tbl[r].poke, cyc);
      post_run($sformatf("row%0d", r), tbl[r].n, cyc, tbl[r].e_cyc, sh0, cap0,
               tbl[r].e_mis, tbl[r].e_mis2, tbl[r].e_fv, tbl[r].e_fp,
               tbl[r].e_fvec, tbl[r].e_fch);
    end

    // Abort at pattern 1 vector 3, then a short N=0 run.
    prep(); finalize(2);
    run(2, -1, 0, L + 3, 1, 1'b0, cyc);
    prep(); finalize(0);
    sh0 = sh_cnt; cap0 = cap_cnt;
    run(0, -1, 0, -1, 0, 1'b0, cyc);
    post_run("after_abort", 0, cyc, 9, sh0, cap0, 0, 0, 1'b0, 0, 0, 0);

    // Five miscompares: the 2-bit counter saturates at 3.
    prep();
    flip_a[L + 2] = 4'b0111;
    flip_a[L + 4] = 4'b0011;
    finalize(1);
    sh0 = sh_cnt; cap0 = cap_cnt;
    run(1, -1, 0, -1, 0, 1'b0, cyc);
    post_run("sat", 1, cyc, 20, sh0, cap0, 5, 3, 1'b1, 1, 2, 0);

    // Reset mid-run after a miscompare has been counted.
    prep();
    flip_a[L + 1] = 4'b0001;
    finalize(1);
    run(1, -1, 0, L + 4, 2, 1'b0, cyc);

    // Randomized runs against the reference model.
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(0, 3);
      prep();
      for (int i = 0; i < (n + 1) * L; i++) begin
        if ($urandom_range(0, 5) == 0) flip_a[i] = NC'($urandom);
        if ($urandom_range(0, 3) == 0) mo_a[i] = NC'($urandom);
      end
      finalize(n);
      st_len = $urandom_range(0, 4);
      st_at = $urandom_range(0, n) * L + $urandom_range(1, L - 1);
      model(n, (1 << MW) - 1, mis, fv, fp, fvec, fch);
      model(n, 3, mis2, fv, fp, fvec, fch);
      sh0 = sh_cnt; cap0 = cap_cnt;
      run(n, st_at, st_len, -1, 0, 1'b0, cyc);
      post_run($sformatf("rand%0d", t), n, cyc, (n + 1) * L + 3 * n + 1 + st_len,
               sh0, cap0, mis, mis2, fv, fp, fvec, fch);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_pat_engine.md
# scan_pat_engine

On-chip scan pattern applier for the chiptop family: replays ATPG load/unload/capture sequences over NCHAIN parallel scan chains and compares unloaded responses against masked expected data. Sits between the test-access pattern buffer (a beat stream) and the core scan chains. It supports production self-replay and serial/parallel debug without an external tester. It tracks pattern and vector numbers, counts miscompares, and records the first failure location for diagnosis.

## Interface
- NCHAIN, 8: number of parallel scan chains (1..64)
- CHAIN_LEN, 256: shift cycles per load/unload (≥2)
- PAT_W, 16: pattern counter width
- MIS_W, 16: miscompare counter width
- clk in 1: single clock; all logic rises on clk
- rst in 1: synchronous, active-high reset
- start in 1: one-cycle pulse; accepted only in IDLE or DONE
- abort in 1: return to IDLE next cycle from any state
- num_pat in PAT_W: capture count N; sampled on accepted start
- beat_valid in 1 / beat_ready out 1: pattern beat handshake
- beat_si in NCHAIN: stimulus bit per chain
- beat_exp in NCHAIN: expected unload bit per chain
- beat_msk in NCHAIN: 1 = compare this chain's bit
- scan_so in NCHAIN: chain outputs
- scan_si out NCHAIN: chain inputs
- scan_en out 1: scan enable
- shift_clk_en out 1: gate enable for the shift clock
- cap_clk_en out 1: gate enable for the capture clock
- busy out 1, done out 1
- pattern_number out PAT_W, vector_number out clog2(CHAIN_LEN)
- mis_cnt out MIS_W: saturating miscompare count
- fail_vld out 1, fail_pat out PAT_W, fail_vec out clog2(CHAIN_LEN), fail_chain out clog2(NCHAIN): first failure

## Operation
- States: IDLE, SHIFT, SE_FALL, CAPTURE, SE_RISE, DONE.
- IDLE/DONE + start: latch num_pat, clear counters and the fail record, go to SHIFT. done is held until start or abort.
- Run structure: N+1 shift groups of CHAIN_LEN beats each, with one capture between consecutive groups.
  - Group 0 expect data is the unload of reset state; the stream masks it.
  - Group N loads the final stimulus. That stimulus is don't-care, and the group only unloads.
- SHIFT with beat_valid=1:
  - beat_ready=1, shift_clk_en=1, scan_si=beat_si.
  - Compare scan_so ^ beat_exp, bitwise-and beat_msk. scan_so is sampled before the shift edge.
  - Increment vector_number.
- SHIFT with beat_valid=0: stall. scan_en stays 1, shift_clk_en=0, beat_ready=0, and no counters move.
- End of a group (vector_number = CHAIN_LEN-1 accepted):
  - If pattern_number < N: SE_FALL. Otherwise DONE.
  - vector_number wraps to 0.
- SE_FALL: scan_en=0, no clock enables. Next state CAPTURE.
- CAPTURE: scan_en=0, cap_clk_en=1 for exactly 1 cycle. Next state SE_RISE.
- SE_RISE: scan_en=1, no clock enables. pattern_number increments, then SHIFT.
- Any nonzero masked compare in an accepted beat:
  - mis_cnt += popcount, saturating at 2^MIS_W-1.
  - If fail_vld=0: set fail_vld and latch pattern_number, vector_number, and the lowest failing chain index.
- N=0: one shift group, no capture, then DONE.
- start while busy is ignored.
- abort or rst (both apply mid-run):
  - All outputs return to reset values.
  - Beats in flight are not consumed.

## Timing
- Reset values:
  - State IDLE.
  - scan_si, scan_en, shift_clk_en, cap_clk_en, beat_ready, busy, done: all 0.
  - All counters and fail fields: 0.
- Output registration:
  - scan_si, scan_en, shift_clk_en, cap_clk_en are registered: they change on the cycle after the state/beat decision.
  - beat_ready is combinational from state and counters; a beat is accepted when beat_valid and beat_ready are both high on a clk edge.
- Latency and update timing:
  - start → first beat_ready: 1 cycle.
  - Compare result to mis_cnt/fail fields: 1 cycle after the accepting edge.
- Cycle counts:
  - Capture overhead per pattern: 3 cycles (SE_FALL, CAPTURE, SE_RISE).
  - Minimum run length: (N+1)·CHAIN_LEN + 3N + 1 cycles.
- busy is high for SHIFT through SE_RISE. done asserts the cycle after the final beat is accepted.
- Simultaneous abort and start: abort wins.

## Structure
- Package scan_pat_pkg holds:
  - State enum st_e.
  - Localparams VEC_W = $clog2(CHAIN_LEN) and CH_W = $clog2(NCHAIN), as parameterised functions.
  - The saturating-add function.
- Sub-module scan_cmp (NCHAIN): masked XOR, popcount, lowest-set-bit priority encoder, any_fail. Purely combinational.
- Top module holds the FSM, counters, output registers and the fail record.

## Test plan
- NCHAIN=4, CHAIN_LEN=8, N=2, beat_valid always 1, exp=loopback model, msk=F → 3 groups, 2 cap_clk_en pulses; done after 8·3+6+1=31 cycles; mis_cnt=0.
- Same run with beat 5 of pattern 1 exp chain2 flipped and chain1 flipped → mis_cnt=2, fail_pat=1, fail_vec=5, fail_chain=1.
- Same flips with msk=0 on those chains → mis_cnt=0, fail_vld=0.
- beat_valid low for 3 cycles mid-group → shift_clk_en low and vector_number frozen for exactly 3 cycles; total run is 3 cycles longer.
- abort at pattern 1, vector 3 → IDLE next cycle, all outputs at reset values. Subsequent start with N=0 → 8 shifts, no capture, done.
- MIS_W=2, 5 miscompares → mis_cnt saturates at 3; rst mid-run → counters 0 on the next edge.
